seri_div: RTL and testbench

//  Sequential restoring divider: the inverse of seri_mul, one quotient bit per clock.

---
 rtl/seri_div_pkg.sv | 28 ++
 rtl/seri_div_step.sv | 46 ++++
 rtl/seri_div.sv | 147 ++++++++++++++
 tb/tb_seri_div.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seri_div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seri_div_pkg
// Purpose  : Shared definitions for the sequential restoring divider:
//            default widths, FSM state encoding and counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package seri_div_pkg;

    // Default dividend/quotient and divisor/remainder widths
    localparam int DW_DEF = 16;
    localparam int VW_DEF = 8;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_ZERO = 2'd2;

    // The iteration counter must be able to hold the value DW itself
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage : seri_div_pkg
`default_nettype wire

// File: rtl/seri_div_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seri_div_step
// Purpose  : One combinational iteration of restoring division:
//            shift {R,Q} left by one, trial-subtract the divisor from R and
//            keep the difference (setting Q[0]) when it does not go negative.
// Ports    : r_i  [VW:0]   partial remainder in
//            q_i  [DW-1:0] partial quotient / remaining dividend bits in
//            d_i  [VW-1:0] divisor
//            r_o  [VW:0]   partial remainder out
//            q_o  [DW-1:0] partial quotient out
// Revision : 1.0 - initial release
// ============================================================================
module seri_div_step #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic [VW:0]   r_i,
    input  logic [DW-1:0] q_i,
    input  logic [VW-1:0] d_i,
    output logic [VW:0]   r_o,
    output logic [DW-1:0] q_o
);

    logic [VW+1:0] shift_r;
    logic [VW:0]   diff;
    logic          ge;

    always_comb begin
        // Keep the full shifted value so the compare sees every bit of R
        shift_r = {r_i, q_i[DW-1]};
        ge      = (shift_r >= {2'b00, d_i});
        // When ge holds the difference is below d_i, so VW+1 bits suffice
        diff    = shift_r[VW:0] - {1'b0, d_i};
        if (ge) begin
            r_o = diff;
            q_o = {q_i[DW-2:0], 1'b1};
        end else begin
            r_o = shift_r[VW:0];
            q_o = {q_i[DW-2:0], 1'b0};
        end
    end

endmodule : seri_div_step
`default_nettype wire

// File: rtl/seri_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seri_div
// Purpose  : Sequential restoring divider, one quotient bit per clock.
//            Start-pulse / op_done handshake; divide-by-zero flagged after a
//            single cycle with an all-ones quotient.
// Ports    : clk        system clock, rising edge
//            rstn       asynchronous active-low reset
//            div_a      [DW-1:0] dividend, sampled on the start edge
//            div_b      [VW-1:0] divisor, sampled on the start edge
//            en_div     start pulse, acted on only while idle
//            quotient   [DW-1:0] result, held until the next op_done
//            remainder  [VW-1:0] result, held until the next op_done
//            div_zero   divisor was zero on the last completed op
//            busy       operation in progress
//            op_done    one-cycle pulse when results update
// Revision : 1.0 - initial release
// ============================================================================
module seri_div
    import seri_div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] div_a,
    input  logic [VW-1:0] div_b,
    input  logic          en_div,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic          busy,
    output logic          op_done
);

    localparam int CNT_W = cnt_width(DW);

    state_t        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [VW:0]   r_q, r_d;
    logic [VW-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;
    logic          op_done_q, op_done_d;

    logic [VW:0]   step_r;
    logic [DW-1:0] step_q;

    seri_div_step #(
        .DW (DW),
        .VW (VW)
    ) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        op_done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (en_div) begin
                    if (div_b != '0) begin
                        state_d = S_CALC;
                        q_d     = div_a;
                        d_d     = div_b;
                        r_d     = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_ZERO;
                    end
                end
            end
            S_CALC: begin
                // DW iterations, then one more edge to publish the results
                if (cnt_q == CNT_W'(DW)) begin
                    state_d     = S_IDLE;
                    quotient_d  = q_q;
                    remainder_d = r_q[VW-1:0];
                    div_zero_d  = 1'b0;
                    op_done_d   = 1'b1;
                end else begin
                    q_d   = step_q;
                    r_d   = step_r;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ZERO: begin
                state_d     = S_IDLE;
                quotient_d  = '1;
                remainder_d = '0;
                div_zero_d  = 1'b1;
                op_done_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            op_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            op_done_q   <= op_done_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign busy      = (state_q != S_IDLE);
    assign op_done   = op_done_q;

endmodule : seri_div
`default_nettype wire

// File: tb/tb_seri_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seri_div
// Purpose  : Self-checking bench for seri_div using a result scoreboard
//            filled from a behavioural a/b, a%b model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seri_div;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] div_a = '0;
    logic [7:0]  div_b = '0;
    logic        en_div = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        busy;
    logic        op_done;

    typedef struct packed {
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;

    seri_div #(.DW(16), .VW(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .div_a     (div_a),
        .div_b     (div_b),
        .en_div    (en_div),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .busy      (busy),
        .op_done   (op_done)
    );

    always #10 clk = ~clk;

    function automatic res_t model(input logic [15:0] a, input logic [7:0] b);
        res_t m;
        if (b == 8'd0) begin
            m.q = 16'hFFFF;
            m.r = 8'd0;
            m.z = 1'b1;
        end else begin
            m.q = a / {8'd0, b};
            m.r = 8'(a % {8'd0, b});
            m.z = 1'b0;
        end
        return m;
    endfunction

    // Called at a negedge; returns at the negedge right after the start edge
    task automatic start_op(input logic [15:0] a, input logic [7:0] b);
        sb.push_back(model(a, b));
        div_a  = a;
        div_b  = b;
        en_div = 1'b1;
        @(negedge clk);
        en_div = 1'b0;
    endtask

    // Negedges counted until op_done is seen; -1 on timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (op_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (49) @(negedge clk);
        checks++;
        if ({quotient, remainder, div_zero, busy, op_done} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got q=%h r=%h z=%b busy=%b done=%b expected all 0",
                     quotient, remainder, div_zero, busy, op_done);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, op_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b done=%b expected 0 0", busy, op_done);
        end
    endtask

    task automatic test_products();
        logic [15:0] ta [4] = '{16'd4005, 16'd1365, 16'd5265, 16'd26865};
        logic [7:0]  tb [4] = '{8'd89, 8'd39, 8'd39, 8'd199};
        res_t e, got;
        int lat;
        for (int k = 0; k < 4; k++) begin
            start_op(ta[k], tb[k]);
            wait_done(lat);
            checks++;
            if (lat !== 17) begin
                failures++;
                $display("FAIL product_latency[%0d]: got %0d expected 17", k, lat);
            end
            if (sb.size() == 0) e = '1; else e = sb.pop_front();
            got = {quotient, remainder, div_zero};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL product_result[%0d]: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                         k, got.q, got.r, got.z, e.q, e.r, e.z);
            end
            @(negedge clk);
            checks++;
            if (op_done !== 1'b0) begin
                failures++;
                $display("FAIL done_width[%0d]: got op_done=%b expected 0", k, op_done);
            end
        end
    endtask

    task automatic test_general();
        logic [15:0] ta [4] = '{16'd100, 16'd65535, 16'd5, 16'd255};
        logic [7:0]  tb [4] = '{8'd7, 8'd1, 8'd200, 8'd255};
        res_t e, got;
        int lat;
        for (int k = 0; k < 4; k++) begin
            start_op(ta[k], tb[k]);
            wait_done(lat);
            if (sb.size() == 0) e = '1; else e = sb.pop_front();
            got = {quotient, remainder, div_zero};
            checks++;
            if (lat < 0 || got !== e) begin
                failures++;
                $display("FAIL general_result[%0d]: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b",
                         k, got.q, got.r, got.z, lat, e.q, e.r, e.z);
            end
        end
    endtask

    task automatic test_zero();
        res_t e, got;
        int lat;
        start_op(16'd1000, 8'd0);
        wait_done(lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL zero_latency: got %0d expected 1", lat);
        end
        if (sb.size() == 0) e = '1; else e = sb.pop_front();
        got = {quotient, remainder, div_zero};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL zero_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                     got.q, got.r, got.z, e.q, e.r, e.z);
        end
        start_op(16'd10, 8'd3);
        wait_done(lat);
        if (sb.size() == 0) e = '1; else e = sb.pop_front();
        got = {quotient, remainder, div_zero};
        checks++;
        if (lat < 0 || got !== e) begin
            failures++;
            $display("FAIL after_zero_result: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b",
                     got.q, got.r, got.z, lat, e.q, e.r, e.z);
        end
    endtask

    task automatic test_busy_ignore();
        res_t e, got;
        int n = 0;
        int lat = -1;
        start_op(16'd100, 8'd7);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                div_a  = 16'd9;
                div_b  = 8'd3;
                en_div = 1'b1;
            end
            if (i == 6) en_div = 1'b0;
            if (op_done) begin
                n++;
                if (n == 1) lat = i;
            end
        end
        checks++;
        if (n !== 1 || lat !== 17) begin
            failures++;
            $display("FAIL busy_ignore_pulses: got %0d pulses first at %0d expected 1 pulse at 17", n, lat);
        end
        if (sb.size() == 0) e = '1; else e = sb.pop_front();
        got = {quotient, remainder, div_zero};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL busy_ignore_result: got q=%0d r=%0d z=%b expected q=%0d r=%0d z=%b",
                     got.q, got.r, got.z, e.q, e.r, e.z);
        end
    endtask

    task automatic test_back_to_back();
        res_t e, got;
        int lat;
        div_a  = 16'd50;
        div_b  = 8'd6;
        en_div = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(model(16'd50, 8'd6));
        for (int k = 0; k < 3; k++) begin
            wait_done(lat);
            if (k == 2) en_div = 1'b0;
            if (sb.size() == 0) e = '1; else e = sb.pop_front();
            got = {quotient, remainder, div_zero};
            checks++;
            if (lat < 0 || got !== e) begin
                failures++;
                $display("FAIL b2b_result[%0d]: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b",
                         k, got.q, got.r, got.z, lat, e.q, e.r, e.z);
            end
        end
        en_div = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        res_t e, got;
        int n = 0;
        int lat;
        start_op(16'd4005, 8'd89);
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({quotient, remainder, div_zero, busy, op_done} !== 27'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got q=%h r=%h z=%b busy=%b done=%b expected all 0",
                     quotient, remainder, div_zero, busy, op_done);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (op_done) n++;
        end
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (op_done) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", n);
        end
        start_op(16'd4005, 8'd89);
        wait_done(lat);
        if (sb.size() == 0) e = '1; else e = sb.pop_front();
        got = {quotient, remainder, div_zero};
        checks++;
        if (lat !== 17 || got !== e) begin
            failures++;
            $display("FAIL midreset_recover: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b lat=17",
                     got.q, got.r, got.z, lat, e.q, e.r, e.z);
        end
    endtask

    task automatic test_random();
        res_t e, got;
        int lat;
        int exp_lat;
        logic [15:0] a;
        logic [7:0]  b;
        for (int k = 0; k < 2000; k++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'd0;
                1: b = 8'hFF;
                2: a = 16'hFFFF;
                3: a = 16'd0;
                4: b = 8'd1;
                5: begin a = 16'hFFFF; b = 8'hFF; end
                default: ;
            endcase
            exp_lat = (b == 8'd0) ? 1 : 17;
            start_op(a, b);
            wait_done(lat);
            if (sb.size() == 0) e = '1; else e = sb.pop_front();
            got = {quotient, remainder, div_zero};
            checks++;
            if (lat != exp_lat || got !== e) begin
                failures++;
                $display("FAIL random[%0d] %0d/%0d: got q=%0d r=%0d z=%b lat=%0d expected q=%0d r=%0d z=%b lat=%0d",
                         k, a, b, got.q, got.r, got.z, lat, e.q, e.r, e.z, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_general();
        test_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seri_div
`default_nettype wire
